csr_file: RTL and testbench

Machine-mode CSR register file and trap responder for the single-cycle rv32i core. It executes the SYSTEM-opcode control signals produced by the CSR decoder: CSR reads and writes (CSRRW/CSRRWI), ECALL/EBREAK/MRET, and the external interrupt. It owns the trap state and the 64-bit cycle and instret counters. It sits beside the register file and drives the PC redirect and the instruction kill into the datapath.

---
 rtl/csr_file.sv | 179 +++++++++++++++++
 tb/tb_csr_file.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file, trap/mret sequencing and 64-bit
// cycle/instret counters for the single-cycle rv32i core.
module csr_file #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic        csr_w,
  input  logic        csr_data_s,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        irq,
  output logic [31:0] rd_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        kill
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;

  logic        irq_meta_r;
  logic        meip_r;
  logic        mie_r;
  logic        mpie_r;
  logic        meie_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  logic        int_take_s;
  logic        exc_s;
  logic        trap_s;
  logic        mret_s;
  logic        csr_we_s;
  logic        retire_s;
  logic [31:0] wdata_s;
  logic [31:0] mstatus_s;
  logic [31:0] trap_cause_s;

  assign int_take_s = instr_valid & meip_r & mie_r & meie_r;
  assign exc_s      = instr_valid & (ecall | ebreak);
  assign trap_s     = int_take_s | exc_s;
  assign mret_s     = instr_valid & mret & ~trap_s;
  assign csr_we_s   = instr_valid & csr_w & ~trap_s & ~mret_s;
  assign retire_s   = instr_valid & ~int_take_s & ~ecall & ~ebreak;
  assign wdata_s    = csr_data_s ? {27'd0, uimm} : rs1_data;
  // MPP is hardwired to machine mode.
  assign mstatus_s  = {19'd0, 2'b11, 3'd0, mpie_r, 3'd0, mie_r, 3'd0};

  // Cause code for a trap taken this cycle; the interrupt outranks exceptions.
  always_comb begin
    trap_cause_s = CAUSE_EBREAK;
    if (int_take_s) begin
      trap_cause_s = CAUSE_MEI;
    end else if (ecall) begin
      trap_cause_s = CAUSE_ECALL;
    end else begin
      trap_cause_s = CAUSE_EBREAK;
    end
  end

  // CSR read mux; shows pre-write state so rd sees the old value.
  always_comb begin
    rd_data = 32'd0;
    case (csr_addr)
      ADDR_MSTATUS:   rd_data = mstatus_s;
      ADDR_MIE:       rd_data = {20'd0, meie_r, 11'd0};
      ADDR_MTVEC:     rd_data = mtvec_r;
      ADDR_MSCRATCH:  rd_data = mscratch_r;
      ADDR_MEPC:      rd_data = mepc_r;
      ADDR_MCAUSE:    rd_data = mcause_r;
      ADDR_MIP:       rd_data = {20'd0, meip_r, 11'd0};
      ADDR_MCYCLE:    rd_data = mcycle_r[31:0];
      ADDR_MCYCLEH:   rd_data = mcycle_r[63:32];
      ADDR_MINSTRET:  rd_data = minstret_r[31:0];
      ADDR_MINSTRETH: rd_data = minstret_r[63:32];
      default:        rd_data = 32'd0;
    endcase
  end

  // PC redirect and kill for traps and mret.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    kill        = 1'b0;
    if (trap_s) begin
      redirect    = 1'b1;
      redirect_pc = mtvec_r;
      kill        = int_take_s;
    end else if (mret_s) begin
      redirect    = 1'b1;
      redirect_pc = mepc_r;
    end else begin
      redirect    = 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous external interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_meta_r <= 1'b0;
      meip_r     <= 1'b0;
    end else begin
      irq_meta_r <= irq;
      meip_r     <= irq_meta_r;
    end
  end

  // Trap state and software-writable CSRs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      meie_r     <= 1'b0;
      mtvec_r    <= {RESET_MTVEC[31:2], 2'b00};
      mscratch_r <= 32'd0;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
    end else if (trap_s) begin
      mepc_r   <= {pc[31:2], 2'b00};
      mcause_r <= trap_cause_s;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (mret_s) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (csr_we_s) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_r  <= wdata_s[3];
          mpie_r <= wdata_s[7];
        end
        ADDR_MIE:      meie_r     <= wdata_s[11];
        ADDR_MTVEC:    mtvec_r    <= {wdata_s[31:2], 2'b00};
        ADDR_MSCRATCH: mscratch_r <= wdata_s;
        ADDR_MEPC:     mepc_r     <= {wdata_s[31:2], 2'b00};
        ADDR_MCAUSE:   mcause_r   <= wdata_s;
        default:       ;
      endcase
    end
  end

  // 64-bit cycle and retired-instruction counters; carry into the high half is implicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
      if (retire_s) begin
        minstret_r <= minstret_r + 64'd1;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: scoreboard-driven bench for csr_file covering CSR access,
// ecall/ebreak/mret, the synchronized interrupt, counter carry and async reset.
module tb_csr_file;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] pc;
  logic        csr_w;
  logic        csr_data_s;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic        ecall;
  logic        ebreak;
  logic        mret;
  logic        irq;
  logic [31:0] rd_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        kill;

  int          checks;
  int          errors;
  logic [63:0] instret_model;
  logic [31:0] exp_q[$];
  logic [33:0] ctl_q[$];
  logic [31:0] e_rd;
  logic [33:0] e_ctl;

  csr_file #(.RESET_MTVEC(32'h0000_0004)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc), .csr_w(csr_w),
    .csr_data_s(csr_data_s), .csr_addr(csr_addr), .rs1_data(rs1_data), .uimm(uimm),
    .ecall(ecall), .ebreak(ebreak), .mret(mret), .irq(irq), .rd_data(rd_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .kill(kill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [31:0] p, input logic w, input logic ds,
                       input logic [11:0] a, input logic [31:0] r, input logic [4:0] u,
                       input logic ec, input logic eb, input logic mr, input logic intr);
    @(negedge clk);
    instr_valid = v; pc = p; csr_w = w; csr_data_s = ds; csr_addr = a;
    rs1_data = r; uimm = u; ecall = ec; ebreak = eb; mret = mr;
    if (v && !intr && !ec && !eb) instret_model = instret_model + 64'd1;
    #1;
  endtask

  task automatic idle(input logic [11:0] a);
    drive(1'b0, 32'h0, 1'b0, 1'b0, a, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [11:0] addrs [5] = '{12'h305, 12'h300, 12'h304, 12'hB00, 12'h344};
    logic [31:0] exps  [5] = '{32'h0000_0004, 32'h0000_1800, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      idle(addrs[i]);
      exp_q.push_back(exps[i]);
      ctl_q.push_back(34'd0);
      e_rd = exp_q.pop_front(); e_ctl = ctl_q.pop_front(); checks += 2;
      if (rd_data !== e_rd) begin
        errors++; $display("FAIL reset_read addr %h: got %h expected %h", addrs[i], rd_data, e_rd);
      end
      if ({kill, redirect, redirect_pc} !== e_ctl) begin
        errors++; $display("FAIL reset_ctl: got %h expected %h", {kill, redirect, redirect_pc}, e_ctl);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_csr_write();
    logic [11:0] addrs [6] = '{12'h305, 12'h340, 12'h341, 12'h344, 12'h342, 12'h123};
    logic [31:0] wd    [6] = '{32'h0000_1003, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hA5A5_A5A5, 32'hFFFF_FFFF};
    logic [31:0] pre   [6] = '{32'h0000_0004, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] post  [6] = '{32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0,
                               32'hA5A5_A5A5, 32'h0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h10, 1'b1, 1'b0, addrs[i], wd[i], 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(pre[i]);
      e_rd = exp_q.pop_front(); checks++;
      if (rd_data !== e_rd) begin
        errors++; $display("FAIL write_pre addr %h: got %h expected %h", addrs[i], rd_data, e_rd);
      end
      idle(addrs[i]);
      exp_q.push_back(post[i]);
      e_rd = exp_q.pop_front(); checks++;
      if (rd_data !== e_rd) begin
        errors++; $display("FAIL write_post addr %h: got %h expected %h", addrs[i], rd_data, e_rd);
      end
    end
  endtask

  task automatic test_ecall_mret();
    logic [11:0] addrs [3] = '{12'h341, 12'h342, 12'h300};
    logic [31:0] exps  [3];
    // CSRRWI mstatus with uimm=8 sets MIE; rs1 must be ignored.
    drive(1'b1, 32'h20, 1'b1, 1'b1, 12'h300, 32'hFFFF_FFFF, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h24, 1'b1, 1'b0, 12'h304, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12'h300);
    exp_q.push_back(32'h0000_1808);
    e_rd = exp_q.pop_front(); checks++;
    if (rd_data !== e_rd) begin errors++; $display("FAIL mstatus_mie: got %h expected %h", rd_data, e_rd); end
    idle(12'h304);
    exp_q.push_back(32'h0000_0800);
    e_rd = exp_q.pop_front(); checks++;
    if (rd_data !== e_rd) begin errors++; $display("FAIL mie_meie: got %h expected %h", rd_data, e_rd); end
    // ecall on a bubble does nothing.
    drive(1'b0, 32'h99, 1'b0, 1'b0, 12'h341, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ctl_q.push_back(34'd0);
    e_ctl = ctl_q.pop_front(); checks++;
    if ({kill, redirect, redirect_pc} !== e_ctl) begin
      errors++; $display("FAIL bubble_ecall_ctl: got %h expected %h", {kill, redirect, redirect_pc}, e_ctl);
    end
    for (int t = 0; t < 2; t++) begin
      logic [31:0] tpc;
      tpc = (t == 0) ? 32'h40 : 32'h50;
      drive(1'b1, tpc, 1'b0, 1'b0, 12'h341, 32'h0, 5'd0, (t == 0), (t == 1), 1'b0, 1'b0);
      ctl_q.push_back({1'b0, 1'b1, 32'h0000_1000});
      exp_q.push_back((t == 0) ? 32'hFFFF_FFFC : 32'h0000_0040);
      e_ctl = ctl_q.pop_front(); e_rd = exp_q.pop_front(); checks += 2;
      if ({kill, redirect, redirect_pc} !== e_ctl) begin
        errors++; $display("FAIL trap_ctl[%0d]: got %h expected %h", t, {kill, redirect, redirect_pc}, e_ctl);
      end
      if (rd_data !== e_rd) begin errors++; $display("FAIL trap_mepc_pre[%0d]: got %h expected %h", t, rd_data, e_rd); end
      exps = '{tpc, (t == 0) ? 32'd11 : 32'd3, 32'h0000_1880};
      for (int i = 0; i < 3; i++) begin
        idle(addrs[i]);
        exp_q.push_back(exps[i]);
        e_rd = exp_q.pop_front(); checks++;
        if (rd_data !== e_rd) begin
          errors++; $display("FAIL trap_state[%0d] addr %h: got %h expected %h", t, addrs[i], rd_data, e_rd);
        end
      end
      drive(1'b1, tpc + 32'h4, 1'b0, 1'b0, 12'h300, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      ctl_q.push_back({1'b0, 1'b1, tpc});
      e_ctl = ctl_q.pop_front(); checks++;
      if ({kill, redirect, redirect_pc} !== e_ctl) begin
        errors++; $display("FAIL mret_ctl[%0d]: got %h expected %h", t, {kill, redirect, redirect_pc}, e_ctl);
      end
      idle(12'h300);
      exp_q.push_back(32'h0000_1888);
      e_rd = exp_q.pop_front(); checks++;
      if (rd_data !== e_rd) begin errors++; $display("FAIL mret_mstatus[%0d]: got %h expected %h", t, rd_data, e_rd); end
    end
  endtask

  task automatic test_interrupt();
    logic [11:0] addrs [5] = '{12'h341, 12'h342, 12'h300, 12'h340, 12'hB02};
    logic [31:0] exps  [5];
    logic [31:0] ipc;
    for (int r = 0; r < 2; r++) begin
      ipc = (r == 0) ? 32'h80 : 32'h90;
      for (int s = 0; s < 3; s++) begin
        idle(12'h344);
        irq = 1'b1;
        exp_q.push_back((s == 2) ? 32'h0000_0800 : 32'h0);
        ctl_q.push_back(34'd0);
        e_rd = exp_q.pop_front(); e_ctl = ctl_q.pop_front(); checks += 2;
        if (rd_data !== e_rd) begin errors++; $display("FAIL meip_sync[%0d.%0d]: got %h expected %h", r, s, rd_data, e_rd); end
        if ({kill, redirect, redirect_pc} !== e_ctl) begin
          errors++; $display("FAIL idle_ctl[%0d.%0d]: got %h expected %h", r, s, {kill, redirect, redirect_pc}, e_ctl);
        end
      end
      // Round 1 also raises ecall: the interrupt must win. The CSR write is dropped in both.
      drive(1'b1, ipc, 1'b1, 1'b0, 12'h340, 32'h1234_5678, 5'd0, (r == 1), 1'b0, 1'b0, 1'b1);
      irq = 1'b0;
      ctl_q.push_back({1'b1, 1'b1, 32'h0000_1000});
      e_ctl = ctl_q.pop_front(); checks++;
      if ({kill, redirect, redirect_pc} !== e_ctl) begin
        errors++; $display("FAIL int_ctl[%0d]: got %h expected %h", r, {kill, redirect, redirect_pc}, e_ctl);
      end
      exps = '{ipc, 32'h8000_000B, 32'h0000_1880, 32'hDEAD_BEEF, instret_model[31:0]};
      for (int i = 0; i < 5; i++) begin
        idle(addrs[i]);
        exp_q.push_back(exps[i]);
        e_rd = exp_q.pop_front(); checks++;
        if (rd_data !== e_rd) begin
          errors++; $display("FAIL int_state[%0d] addr %h: got %h expected %h", r, addrs[i], rd_data, e_rd);
        end
      end
      if (r == 0) begin
        drive(1'b1, 32'h84, 1'b0, 1'b0, 12'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        ctl_q.push_back({1'b0, 1'b1, 32'h80});
        e_ctl = ctl_q.pop_front(); checks++;
        if ({kill, redirect, redirect_pc} !== e_ctl) begin
          errors++; $display("FAIL int_mret_ctl: got %h expected %h", {kill, redirect, redirect_pc}, e_ctl);
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    logic [11:0] addrs [4] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82};
    drive(1'b1, 32'hA0, 1'b0, 1'b0, 12'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    force dut.mcycle_r = 64'h0000_0000_FFFF_FFFF;
    force dut.minstret_r = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.mcycle_r;
    release dut.minstret_r;
    drive(1'b1, 32'hA4, 1'b0, 1'b0, 12'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(addrs[i]);
      exp_q.push_back(32'h1);
      e_rd = exp_q.pop_front(); checks++;
      if (rd_data !== e_rd) begin
        errors++; $display("FAIL counter_wrap addr %h: got %h expected %h", addrs[i], rd_data, e_rd);
      end
    end
  endtask

  task automatic test_reset_mid_trap();
    logic [11:0] addrs [9] = '{12'hB80, 12'hB02, 12'hB82, 12'h341, 12'h342, 12'h300,
                               12'h305, 12'h340, 12'h304};
    logic [31:0] exps  [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_1800,
                               32'h0000_0004, 32'h0, 32'h0};
    drive(1'b1, 32'h100, 1'b1, 1'b0, 12'hB00, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    e_rd = exp_q.pop_front(); checks++;
    if (rd_data !== e_rd) begin errors++; $display("FAIL reset_immediate mcycle: got %h expected %h", rd_data, e_rd); end
    for (int i = 0; i < 9; i++) begin
      idle(addrs[i]);
      exp_q.push_back(exps[i]);
      e_rd = exp_q.pop_front(); checks++;
      if (rd_data !== e_rd) begin
        errors++; $display("FAIL reset_mid addr %h: got %h expected %h", addrs[i], rd_data, e_rd);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    instret_model = 64'd0;
    idle(12'h341);
    idle(12'hB02);
    exp_q.push_back(instret_model[31:0]);
    e_rd = exp_q.pop_front(); checks++;
    if (rd_data !== e_rd) begin errors++; $display("FAIL post_reset minstret: got %h expected %h", rd_data, e_rd); end
  endtask

  initial begin
    checks = 0; errors = 0; instret_model = 64'd0;
    rst_n = 1'b0; irq = 1'b0; instr_valid = 1'b0; pc = 32'h0; csr_w = 1'b0;
    csr_data_s = 1'b0; csr_addr = 12'h0; rs1_data = 32'h0; uimm = 5'd0;
    ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
    test_reset();
    test_csr_write();
    test_ecall_mret();
    test_interrupt();
    test_counter_wrap();
    test_reset_mid_trap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
